rd_data2blk: RTL and testbench
==============================

# rd_data2blk

Memory-to-block reader for the SHA datapath. On a start pulse it reads N_WORDS consecutive 32-bit words from data memory, beginning at BASE_ADDR, and packs them big-endian into a 512-bit message block for the SHA core. It is the read-side counterpart of the SHA-result write-back path: same address stride (4), same word order (word 0 in the block MSBs).

## Interface

Parameters:
- BASE_ADDR, 32'd0, byte address of word 0.
- N_WORDS, 16, words per block (fixed at 16 for a 512-bit block).
- RD_LATENCY, 1, cycles from an `en_r_datamem` cycle to valid `data_mem_in`; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to fetch a block; sampled only in IDLE.
- en_r_datamem  out  1  memory read enable.
- addr_mem  out  32  memory byte address.
- data_mem_in  in  32  read data, valid RD_LATENCY cycles after its enable cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; `block_out` is updated in the same cycle.
- block_out  out  512  assembled block; word i occupies [511-32i -: 32].

## Operation

- Reset values: all outputs 0, including `block_out`, `addr_mem`, `done` and `busy`. All internal counters and the shadow buffer are also 0, and the FSM is in IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 moves the FSM to ISSUE.
  - On that same edge the block registers `en_r_datamem`=1, `addr_mem`=BASE_ADDR, `busy`=1 and clears the issue and capture counters.
- ISSUE:
  - One read is issued per cycle. `addr_mem` = BASE_ADDR + 4*issue_idx.
  - After N_WORDS reads, `en_r_datamem` drops to 0 and the FSM moves to DRAIN.
- DRAIN: the FSM waits until capture_idx == N_WORDS, then moves to DONE.
- Capture path:
  - A valid pipe of depth RD_LATENCY tracks each issued read.
  - When the pipe output is 1, `data_mem_in` is written to shadow[capture_idx] and capture_idx increments.
  - Capture runs in both ISSUE and DRAIN.
- DONE (one cycle):
  - `block_out` is loaded from shadow, `done`=1, `busy`=0.
  - The next state is IDLE.
- `block_out` never shows a partially filled block. It holds its value until the next DONE.
- `start` while `busy` is ignored: no queuing and no restart.
- `start` in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.
- Address arithmetic is 32-bit, modulo 2^32. BASE_ADDR + 60 wraps silently; no error flag.
- Asserting reset mid-operation aborts immediately:
  - All outputs return to their reset values and `block_out` is cleared to 0.
  - Read data still in flight after reset is released is discarded, because the valid pipe is cleared.

## Timing

- Cycle numbering: cycle 0 is the cycle whose closing edge samples `start`=1.
- `en_r_datamem`=1 in cycles 1..N_WORDS. Word i is addressed in cycle 1+i.
- Word i is captured at the end of cycle 1+i+RD_LATENCY.
- `done`=1 in cycle N_WORDS+RD_LATENCY+1, which is cycle 18 for the defaults.
- `busy`=1 in cycles 1..N_WORDS+RD_LATENCY, and 0 in the done cycle.
- Minimum start-to-start spacing is N_WORDS+RD_LATENCY+2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure

- Package `sha_mem_pkg`:
  - WORD_W=32, BLK_W=512, BLK_WORDS=16, ADDR_STRIDE=4.
  - FSM state enum (2 bits).
  - Shared with the write-back block.
- Sub-module `rd_valid_pipe`:
  - RD_LATENCY-deep shift register of read-valid bits.
  - Asynchronous active-low clear.
  - Reused by any other memory reader.
- Shadow buffer: 16x32 registers, indexed by a 5-bit capture_idx.

## Test plan

- Basic fetch:
  - Stimulus: memory model with word[k]=32'hA5000000+k, BASE_ADDR=0, start pulse.
  - Response: `addr_mem` = 0,4,...,60 in cycles 1..16. `done` in cycle 18. `block_out[511:480]`=32'hA5000000 and `block_out[31:0]`=32'hA500000F.
- Latency sweep:
  - Stimulus: RD_LATENCY=3, same memory.
  - Response: `done` in cycle 20. `block_out` identical to the basic fetch.
- Start while busy:
  - Stimulus: second `start` pulses in cycles 5 and 18.
  - Response: both ignored. Exactly one `done`. `en_r_datamem` asserted for exactly 16 cycles.
- Back-to-back:
  - Stimulus: second start in cycle 19 with memory contents changed to ~word[k].
  - Response: second `done` in cycle 37.
  - Response: `block_out` keeps the first block's value until then, and equals the inverted data after.
- Reset mid-operation:
  - Stimulus: reset low in cycle 9, released in cycle 11, then a fresh start.
  - Response: all outputs 0 while reset is low, with no `done`.
  - Response: the next block completes correctly, with no stale words from the aborted fetch.
- Address wrap:
  - Stimulus: BASE_ADDR=32'hFFFFFFF0.
  - Response: addresses FFFFFFF0, FFFFFFF4, FFFFFFF8, FFFFFFFC, 0, 4, ... 2C. `done` in cycle 18.

Source files
------------

// File: rtl/sha_mem_pkg.sv
// Shared constants and FSM state type for the SHA datapath memory readers and writers.
package sha_mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLK_W       = 512;
  localparam int unsigned BLK_WORDS   = 16;
  localparam int unsigned ADDR_STRIDE = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } mem_state_e;

endpackage

// File: rtl/rd_valid_pipe.sv
// Shift register tracking which memory read slots return valid data.
module rd_valid_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic valid_o
);

  logic [Depth-1:0] pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= valid_i;
      for (int i = 1; i < int'(Depth); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[Depth-1];

endmodule

// File: rtl/rd_data2blk.sv
// Reads a run of 32-bit words from data memory and packs them big-endian into a 512-bit block.
module rd_data2blk
  import sha_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter int unsigned N_WORDS    = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               en_r_datamem,
  output logic [WORD_W-1:0]  addr_mem,
  input  logic [WORD_W-1:0]  data_mem_in,
  output logic               busy,
  output logic               done,
  output logic [BLK_W-1:0]   block_out
);

  mem_state_e        state_q, state_d;
  logic [4:0]        issue_idx_q, issue_idx_d;
  logic [4:0]        capture_idx_q, capture_idx_d;
  logic [WORD_W-1:0] shadow_q [BLK_WORDS];
  logic [WORD_W-1:0] shadow_d [BLK_WORDS];
  logic              en_q, en_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BLK_W-1:0]  block_q, block_d;
  logic              cap_valid;

  rd_valid_pipe #(
    .Depth (RD_LATENCY)
  ) u_valid_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (en_q),
    .valid_o (cap_valid)
  );

  always_comb begin
    state_d       = state_q;
    issue_idx_d   = issue_idx_q;
    capture_idx_d = capture_idx_q;
    shadow_d      = shadow_q;
    en_d          = en_q;
    addr_d        = addr_q;
    busy_d        = busy_q;
    done_d        = done_q;
    block_d       = block_q;

    if (cap_valid && (capture_idx_q < 5'(N_WORDS)) &&
        ((state_q == StIssue) || (state_q == StDrain))) begin
      shadow_d[capture_idx_q[3:0]] = data_mem_in;
      capture_idx_d                = capture_idx_q + 5'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StIssue;
          en_d          = 1'b1;
          addr_d        = BASE_ADDR;
          busy_d        = 1'b1;
          issue_idx_d   = '0;
          capture_idx_d = '0;
        end
      end
      StIssue: begin
        issue_idx_d = issue_idx_q + 5'd1;
        if (issue_idx_q == 5'(N_WORDS - 1)) begin
          en_d    = 1'b0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 32'(ADDR_STRIDE);
        end
      end
      StDrain: begin
        // Look at the post-capture count so done lands the cycle after the last word.
        if (capture_idx_d == 5'(N_WORDS)) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          for (int i = 0; i < int'(BLK_WORDS); i++) begin
            block_d[BLK_W-1-WORD_W*i -: WORD_W] = shadow_d[i];
          end
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      issue_idx_q   <= '0;
      capture_idx_q <= '0;
      en_q          <= 1'b0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      block_q       <= '0;
      for (int i = 0; i < int'(BLK_WORDS); i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      issue_idx_q   <= issue_idx_d;
      capture_idx_q <= capture_idx_d;
      en_q          <= en_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      block_q       <= block_d;
      shadow_q      <= shadow_d;
    end
  end

  assign en_r_datamem = en_q;
  assign addr_mem     = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign block_out    = block_q;

endmodule

// File: tb/tb_rd_data2blk.sv
// Directed bench for rd_data2blk: default, latency-3 and wrapping-base instances.
module tb_rd_data2blk;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic inv = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic         start0 = 1'b0, start3 = 1'b0, startw = 1'b0;
  logic         en0, en3, enw, busy0, busy3, busyw, done0, done3, donew;
  logic [31:0]  addr0, addr3, addrw, rd0, rd3, rdw;
  logic [511:0] blk0, blk3, blkw;

  rd_data2blk u_dut0 (
    .clk (clk), .reset (reset), .start (start0), .en_r_datamem (en0), .addr_mem (addr0),
    .data_mem_in (rd0), .busy (busy0), .done (done0), .block_out (blk0)
  );

  rd_data2blk #(.RD_LATENCY (3)) u_dut3 (
    .clk (clk), .reset (reset), .start (start3), .en_r_datamem (en3), .addr_mem (addr3),
    .data_mem_in (rd3), .busy (busy3), .done (done3), .block_out (blk3)
  );

  rd_data2blk #(.BASE_ADDR (32'hFFFF_FFF0)) u_dutw (
    .clk (clk), .reset (reset), .start (startw), .en_r_datamem (enw), .addr_mem (addrw),
    .data_mem_in (rdw), .busy (busyw), .done (donew), .block_out (blkw)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] off, input logic iv);
    logic [31:0] w;
    w = 32'hA500_0000 + {28'h0, off[5:2]};
    return iv ? ~w : w;
  endfunction

  function automatic logic [511:0] exp_block(input logic iv);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = mem_word(32'(4 * i), iv);
    return b;
  endfunction

  // Memory models; idle slots return a sentinel so stray captures show up.
  logic [31:0] m0_q, mw_q;
  logic [31:0] m3_q [3];
  always @(posedge clk) begin
    m0_q    <= en0 ? mem_word(addr0, inv) : 32'hDEAD_BEEF;
    mw_q    <= enw ? mem_word(addrw - 32'hFFFF_FFF0, inv) : 32'hDEAD_BEEF;
    m3_q[0] <= en3 ? mem_word(addr3, inv) : 32'hDEAD_BEEF;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign rd0 = m0_q;
  assign rdw = mw_q;
  assign rd3 = m3_q[2];

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({en0, busy0, done0} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl0: got %b want 000", {en0, busy0, done0});
    end
    checks++;
    if (addr0 !== 32'h0) begin errors++; $display("FAIL reset_addr0: got %h want 0", addr0); end
    checks++;
    if (blk0 !== 512'h0) begin errors++; $display("FAIL reset_blk0: got %h want 0", blk0); end
    checks++;
    if ({en3, busy3, done3, enw, busyw, donew} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl3w: got %b want 000000",
                         {en3, busy3, done3, enw, busyw, donew});
    end
    checks++;
    if ((blk3 | blkw) !== 512'h0) begin
      errors++; $display("FAIL reset_blk3w: got %h want 0", blk3 | blkw);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      checks++;
      if (en0 !== logic'(c <= 16)) begin
        errors++; $display("FAIL basic_en c%0d: got %b want %b", c, en0, c <= 16);
      end
      if (c <= 16) begin
        checks++;
        if (addr0 !== 32'(4 * (c - 1))) begin
          errors++; $display("FAIL basic_addr c%0d: got %h want %h", c, addr0, 4 * (c - 1));
        end
      end
      checks++;
      if (busy0 !== logic'(c <= 17)) begin
        errors++; $display("FAIL basic_busy c%0d: got %b want %b", c, busy0, c <= 17);
      end
      checks++;
      if (done0 !== logic'(c == 18)) begin
        errors++; $display("FAIL basic_done c%0d: got %b want %b", c, done0, c == 18);
      end
      if (c == 17) begin
        checks++;
        if (blk0 !== 512'h0) begin errors++; $display("FAIL basic_partial: got %h want 0", blk0); end
      end
      @(negedge clk);
    end
    checks++;
    if (blk0[511:480] !== 32'hA500_0000) begin
      errors++; $display("FAIL basic_word0: got %h want A5000000", blk0[511:480]);
    end
    checks++;
    if (blk0[31:0] !== 32'hA500_000F) begin
      errors++; $display("FAIL basic_word15: got %h want A500000F", blk0[31:0]);
    end
    checks++;
    if (blk0 !== exp_block(1'b0)) begin
      errors++; $display("FAIL basic_block: got %h want %h", blk0, exp_block(1'b0));
    end
  endtask

  task automatic test_latency();
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      checks++;
      if (en3 !== logic'(c <= 16)) begin
        errors++; $display("FAIL lat_en c%0d: got %b want %b", c, en3, c <= 16);
      end
      checks++;
      if (busy3 !== logic'(c <= 19)) begin
        errors++; $display("FAIL lat_busy c%0d: got %b want %b", c, busy3, c <= 19);
      end
      checks++;
      if (done3 !== logic'(c == 20)) begin
        errors++; $display("FAIL lat_done c%0d: got %b want %b", c, done3, c == 20);
      end
      @(negedge clk);
    end
    checks++;
    if (blk3 !== exp_block(1'b0)) begin
      errors++; $display("FAIL lat_block: got %h want %h", blk3, exp_block(1'b0));
    end
  endtask

  task automatic test_start_busy();
    int n_en = 0;
    int n_done = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (en0 === 1'b1) n_en++;
      if (done0 === 1'b1) begin
        n_done++;
        checks++;
        if (c != 18) begin errors++; $display("FAIL busy_done_cycle: got %0d want 18", c); end
      end
      start0 = logic'((c == 5) || (c == 18));
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
    checks++;
    if (n_en != 16) begin errors++; $display("FAIL busy_en_count: got %0d want 16", n_en); end
    checks++;
    if (blk0 !== exp_block(1'b0)) begin
      errors++; $display("FAIL busy_block: got %h want %h", blk0, exp_block(1'b0));
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (done0 !== logic'((c == 18) || (c == 37))) begin
        errors++; $display("FAIL b2b_done c%0d: got %b want %b", c, done0, (c == 18) || (c == 37));
      end
      if ((c == 18) || (c == 36)) begin
        checks++;
        if (blk0 !== exp_block(1'b0)) begin
          errors++; $display("FAIL b2b_first c%0d: got %h want %h", c, blk0, exp_block(1'b0));
        end
      end
      if (c == 37) begin
        checks++;
        if (blk0 !== exp_block(1'b1)) begin
          errors++; $display("FAIL b2b_second: got %h want %h", blk0, exp_block(1'b1));
        end
      end
      if (c == 19) inv = 1'b1;
      start0 = logic'(c == 19);
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int done_cyc = -1;
    inv = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 9) begin reset = 1'b0; #1; end
      if ((c >= 9) && (c <= 11)) begin
        checks++;
        if ({en0, busy0, done0, addr0} !== 35'h0) begin
          errors++; $display("FAIL rst_outs c%0d: got %b %b %b %h want 0", c, en0, busy0, done0,
                             addr0);
        end
        checks++;
        if (blk0 !== 512'h0) begin errors++; $display("FAIL rst_blk c%0d: got %h want 0", c, blk0); end
      end
      if (c == 11) reset = 1'b1;
      checks++;
      if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done c%0d: got %b want 0", c, done0); end
      @(negedge clk);
    end
    inv = 1'b1;
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if ((done0 === 1'b1) && (done_cyc < 0)) done_cyc = c;
      @(negedge clk);
    end
    checks++;
    if (done_cyc != 18) begin errors++; $display("FAIL rst_fresh_done: got %0d want 18", done_cyc); end
    checks++;
    if (blk0 !== exp_block(1'b1)) begin
      errors++; $display("FAIL rst_fresh_block: got %h want %h", blk0, exp_block(1'b1));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    inv = 1'b0;
    @(negedge clk); startw = 1'b1;
    @(negedge clk); startw = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      ea = 32'hFFFF_FFF0 + 32'(4 * (c - 1));
      checks++;
      if (enw !== logic'(c <= 16)) begin
        errors++; $display("FAIL wrap_en c%0d: got %b want %b", c, enw, c <= 16);
      end
      if (c <= 16) begin
        checks++;
        if (addrw !== ea) begin errors++; $display("FAIL wrap_addr c%0d: got %h want %h", c, addrw, ea); end
      end
      checks++;
      if (donew !== logic'(c == 18)) begin
        errors++; $display("FAIL wrap_done c%0d: got %b want %b", c, donew, c == 18);
      end
      @(negedge clk);
    end
    checks++;
    if (blkw !== exp_block(1'b0)) begin
      errors++; $display("FAIL wrap_block: got %h want %h", blkw, exp_block(1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
